fpnormround: RTL and testbench

Normalize-and-round stage that sits directly downstream of the fraction multiplier in the floating-point multiplier datapath. It takes the raw 2Q-bit significand product, the biased exponent sum and the result sign, then normalizes and rounds the result per `round_in`. It packs the sign/exponent/fraction word and flags out-of-range conditions. It uses a valid/ready handshake on both sides and processes one operation at a time.

---
 rtl/fpnormround_if.sv | 28 ++
 rtl/fpnormround.sv | 186 ++++++++++++++++++
 tb/tb_fpnormround.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fpnormround_if.sv
// Handshake and payload bundle between the fraction multiplier, the normalize/round
// stage and the downstream consumer.
interface fpnormround_if #(
    parameter int unsigned P = 8,
    parameter int unsigned Q = 8
);
    logic [2*Q-1:0] prod_in;
    logic [P+1:0]   exp_in;
    logic           sign_in;
    logic           zero_in;
    logic [1:0]     round_in;
    logic           valid_in;
    logic           ready_out;
    logic [P+Q-1:0] p_out;
    logic [3:0]     oor_out;
    logic           valid_out;
    logic           ready_in;

    modport master (
        output prod_in, exp_in, sign_in, zero_in, round_in, valid_in, ready_in,
        input  ready_out, p_out, oor_out, valid_out
    );

    modport slave (
        input  prod_in, exp_in, sign_in, zero_in, round_in, valid_in, ready_in,
        output ready_out, p_out, oor_out, valid_out
    );
endinterface

// File: rtl/fpnormround.sv
// Normalize, round and pack stage for the FP multiplier; one operation in flight,
// valid/ready on both sides.
module fpnormround #(
    parameter int unsigned P = 8,
    parameter int unsigned Q = 8
) (
    input  logic         clk_in,
    input  logic         rst_in,
    fpnormround_if.slave bus
);
    localparam int unsigned W  = P + Q;
    localparam int unsigned PW = 2 * Q;
    localparam int unsigned EW = P + 3;
    localparam int unsigned FW = Q - 1;
    localparam logic signed [EW-1:0] EXP_MAX = EW'((2 ** P) - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_NORM   = 3'd1;
    localparam logic [2:0] S_ROUND  = 3'd2;
    localparam logic [2:0] S_RENORM = 3'd3;
    localparam logic [2:0] S_OUT    = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [PW-1:0]        prod_q, prod_d;
    logic signed [EW-1:0] exp_q, exp_d;
    logic                 sign_q, sign_d;
    logic                 zero_q, zero_d;
    logic [1:0]           round_q, round_d;
    logic [FW-1:0]        frac_q, frac_d;
    logic                 guard_q, guard_d;
    logic                 sticky_q, sticky_d;
    logic [W-1:0]         p_q, p_d;
    logic [3:0]           oor_q, oor_d;
    logic                 valid_q, valid_d;
    logic                 ready_q, ready_d;

    logic                 inc_c;
    logic                 inexact_c;
    logic [Q-1:0]         sum_c;
    logic                 pack_c;
    logic [FW-1:0]        pk_frac_c;
    logic signed [EW-1:0] pk_exp_c;

    // Rounding increment from guard/sticky, mode and sign
    always_comb begin
        inexact_c = guard_q | sticky_q;
        case (round_q)
            2'b00:   inc_c = guard_q & (sticky_q | frac_q[0]);
            2'b01:   inc_c = 1'b0;
            2'b10:   inc_c = inexact_c & ~sign_q;
            default: inc_c = inexact_c & sign_q;
        endcase
        sum_c = {1'b0, frac_q} + Q'(inc_c);
    end

    always_comb begin
        state_d   = state_q;
        prod_d    = prod_q;
        exp_d     = exp_q;
        sign_d    = sign_q;
        zero_d    = zero_q;
        round_d   = round_q;
        frac_d    = frac_q;
        guard_d   = guard_q;
        sticky_d  = sticky_q;
        p_d       = p_q;
        oor_d     = oor_q;
        valid_d   = valid_q;
        ready_d   = ready_q;
        pack_c    = 1'b0;
        pk_frac_c = frac_q;
        pk_exp_c  = exp_q;

        case (state_q)
            S_IDLE: begin
                if (bus.valid_in && ready_q) begin
                    prod_d  = bus.prod_in;
                    exp_d   = {bus.exp_in[P+1], bus.exp_in};
                    sign_d  = bus.sign_in;
                    zero_d  = bus.zero_in;
                    round_d = bus.round_in;
                    ready_d = 1'b0;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (prod_q[PW-1]) begin
                    frac_d   = prod_q[PW-2:Q];
                    guard_d  = prod_q[Q-1];
                    sticky_d = |prod_q[Q-2:0];
                    exp_d    = exp_q + EW'(1);
                end else begin
                    frac_d   = prod_q[PW-3:Q-1];
                    guard_d  = prod_q[Q-2];
                    sticky_d = |prod_q[Q-3:0];
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                frac_d = sum_c[FW-1:0];
                if (sum_c[Q-1] && !zero_q) begin
                    state_d = S_RENORM;
                end else begin
                    pack_c    = 1'b1;
                    pk_frac_c = sum_c[FW-1:0];
                    state_d   = S_OUT;
                end
            end
            S_RENORM: begin
                frac_d    = '0;
                exp_d     = exp_q + EW'(1);
                pack_c    = 1'b1;
                pk_frac_c = '0;
                pk_exp_c  = exp_q + EW'(1);
                state_d   = S_OUT;
            end
            S_OUT: begin
                if (valid_q && bus.ready_in) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase

        // Range check and packing on entry to OUT; zero operand overrides everything
        if (pack_c) begin
            valid_d = 1'b1;
            if (zero_q) begin
                p_d   = {sign_q, {(W-1){1'b0}}};
                oor_d = 4'b1000;
            end else if (pk_exp_c >= EXP_MAX) begin
                p_d   = {sign_q, {P{1'b1}}, {FW{1'b0}}};
                oor_d = 4'b0101;
            end else if (pk_exp_c[EW-1] || (pk_exp_c == '0)) begin
                p_d   = {sign_q, {(W-1){1'b0}}};
                oor_d = 4'b0110;
            end else begin
                p_d   = {sign_q, pk_exp_c[P-1:0], pk_frac_c};
                oor_d = {1'b0, inexact_c, 2'b00};
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            prod_q   <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            round_q  <= 2'b00;
            frac_q   <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            p_q      <= '0;
            oor_q    <= 4'b0000;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            prod_q   <= prod_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            zero_q   <= zero_d;
            round_q  <= round_d;
            frac_q   <= frac_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            p_q      <= p_d;
            oor_q    <= oor_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.p_out     = p_q;
    assign bus.oor_out   = oor_q;
    assign bus.valid_out = valid_q;
    assign bus.ready_out = ready_q;
endmodule

// File: tb/tb_fpnormround.sv
// Directed-vector bench for fpnormround with hand-computed results.
module tb_fpnormround;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fpnormround_if #(.P(8), .Q(8)) bus ();
    fpnormround #(.P(8), .Q(8)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic accept(input logic [15:0] prod, input logic [9:0] ex, input logic sgn,
                          input logic zro, input logic [1:0] rnd);
        @(negedge clk);
        bus.prod_in  = prod;
        bus.exp_in   = ex;
        bus.sign_in  = sgn;
        bus.zero_in  = zro;
        bus.round_in = rnd;
        bus.valid_in = 1'b1;
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (bus.valid_out) break;
            if (lat > 20) begin
                check({tag, "_timeout"}, 32'(lat), 32'd0);
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] prod, input logic [9:0] ex,
                          input logic sgn, input logic zro, input logic [1:0] rnd,
                          input logic [15:0] ep, input logic [3:0] eo, input int elat);
        int lat;
        accept(prod, ex, sgn, zro, rnd);
        wait_valid(tag, lat);
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_p"}, 32'(bus.p_out), 32'(ep));
        check({tag, "_oor"}, 32'(bus.oor_out), 32'(eo));
        @(negedge clk);
        check({tag, "_vdrop"}, 32'(bus.valid_out), 32'd0);
    endtask

    initial begin
        int lat;
        rst          = 1'b1;
        bus.ready_in = 1'b1;
        bus.valid_in = 1'b0;
        bus.prod_in  = '0;
        bus.exp_in   = '0;
        bus.sign_in  = 1'b0;
        bus.zero_in  = 1'b0;
        bus.round_in = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.ready_out), 32'd1);
        check("rst_valid", 32'(bus.valid_out), 32'd0);
        check("rst_p", 32'(bus.p_out), 32'd0);
        check("rst_oor", 32'(bus.oor_out), 32'd0);
        rst = 1'b0;

        run_op("unity",    16'h4000, 10'd127, 1'b0, 1'b0, 2'b00, 16'h3F80, 4'b0000, 3);
        run_op("norm",     16'h9000, 10'd127, 1'b0, 1'b0, 2'b00, 16'h4010, 4'b0000, 3);
        run_op("norm_neg", 16'h9000, 10'd127, 1'b1, 1'b0, 2'b00, 16'hC010, 4'b0000, 3);
        run_op("rne_cry",  16'h7FC0, 10'd127, 1'b0, 1'b0, 2'b00, 16'h4000, 4'b0100, 4);
        run_op("rz",       16'h7FC0, 10'd127, 1'b0, 1'b0, 2'b01, 16'h3FFF, 4'b0100, 3);
        run_op("rninf",    16'h7FC0, 10'd127, 1'b1, 1'b0, 2'b11, 16'hC000, 4'b0100, 4);
        run_op("rpinf_n",  16'h7FC0, 10'd127, 1'b1, 1'b0, 2'b10, 16'hBFFF, 4'b0100, 3);
        run_op("rne_tie",  16'h40C0, 10'd127, 1'b0, 1'b0, 2'b00, 16'h3F82, 4'b0100, 3);
        run_op("ovf",      16'h4000, 10'd255, 1'b0, 1'b0, 2'b00, 16'h7F80, 4'b0101, 3);
        run_op("max_ok",   16'h4000, 10'd254, 1'b0, 1'b0, 2'b00, 16'h7F00, 4'b0000, 3);
        run_op("unf0",     16'h4000, 10'd0,   1'b0, 1'b0, 2'b00, 16'h0000, 4'b0110, 3);
        run_op("unf_neg",  16'h4000, 10'h3FB, 1'b1, 1'b0, 2'b00, 16'h8000, 4'b0110, 3);
        run_op("zero",     16'h7FC0, 10'd300, 1'b1, 1'b1, 2'b00, 16'h8000, 4'b1000, 3);

        // Backpressure: result held, new requests ignored
        bus.ready_in = 1'b0;
        accept(16'h9000, 10'd127, 1'b0, 1'b0, 2'b00);
        wait_valid("bp", lat);
        check("bp_p", 32'(bus.p_out), 32'h4010);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_p", 32'(bus.p_out), 32'h4010);
            check("bp_hold_v", 32'(bus.valid_out), 32'd1);
            check("bp_ready", 32'(bus.ready_out), 32'd0);
            bus.prod_in  = 16'h4000;
            bus.exp_in   = 10'd1;
            bus.valid_in = (i % 2 == 0);
        end
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_rel_v", 32'(bus.valid_out), 32'd0);
        check("bp_rel_r", 32'(bus.ready_out), 32'd1);
        check("bp_keep_p", 32'(bus.p_out), 32'h4010);
        run_op("b2b", 16'h4000, 10'd127, 1'b0, 1'b0, 2'b00, 16'h3F80, 4'b0000, 3);

        // Reset in ROUND aborts the operation
        accept(16'h7FC0, 10'd200, 1'b1, 1'b0, 2'b00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mrst_valid", 32'(bus.valid_out), 32'd0);
        check("mrst_p", 32'(bus.p_out), 32'd0);
        check("mrst_oor", 32'(bus.oor_out), 32'd0);
        check("mrst_ready", 32'(bus.ready_out), 32'd1);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("mrst_noemit", 32'(bus.valid_out), 32'd0);
        run_op("post_rst", 16'h9000, 10'd127, 1'b1, 1'b0, 2'b00, 16'hC010, 4'b0000, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
